// File: rtl/r8_pp_generator.sv
// Radix-8 Booth partial-product generator: two-stage valid/ready pipeline feeding a Dadda tree.
// Optional transfer counter enabled by defining R8_PPGEN_OPCOUNT_EN.
module r8_pp_generator #(
  parameter int unsigned N = 16,
  localparam int unsigned NPP = (N + 2) / 3,
  localparam int unsigned W = N + 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     x_in,
  input  logic [N-1:0]     y_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NPP*W-1:0] pp_out,
  output logic [NPP-1:0]   neg_out,
  output logic [15:0]      op_count
);

  localparam int unsigned XW = N + 2;
  localparam int unsigned YW = 3 * NPP + 1;
  localparam int unsigned CW = 5;

  logic              a_valid;
  logic              b_valid;
  logic [N-1:0]      a_x;
  logic [XW-1:0]     a_x3;
  logic [NPP*CW-1:0] a_code;

  logic              b_adv;
  logic              a_adv;
  logic              in_fire;
  logic [XW-1:0]     x3_d;
  logic [NPP*CW-1:0] code_d;
  logic [NPP*W-1:0]  pp_d;
  logic [NPP-1:0]    neg_d;

  assign b_adv    = ~b_valid | out_ready;
  assign a_adv    = a_valid & b_adv;
  assign in_ready = ~a_valid | a_adv;
  assign in_fire  = in_valid & in_ready;
  assign out_valid = b_valid;

  assign x3_d = XW'($signed(x_in)) + (XW'($signed(x_in)) << 1);

  // Booth windows over Y sign-extended to 3*NPP bits with an implicit Y[-1]=0
  always_comb begin
    logic [YW-1:0] yw;
    logic [3:0]    win;
    logic [2:0]    sum;
    logic [2:0]    mag;
    code_d = '0;
    yw     = {(YW-1)'($signed(y_in)), 1'b0};
    win    = '0;
    sum    = '0;
    mag    = '0;
    for (int i = 0; i < int'(NPP); i++) begin
      win = yw[3*i +: 4];
      sum = 3'({win[2], 1'b0}) + 3'(win[1]) + 3'(win[0]);
      mag = win[3] ? (3'd4 - sum) : sum;
      code_d[CW*i +: CW] = {win[3], mag == 3'd4, mag == 3'd3, mag == 3'd2, mag == 3'd1};
    end
  end

  // Row selection: |d|*X, inverted for negative digits; the +1 goes out on neg
  always_comb begin
    logic [CW-1:0] c;
    logic [W-1:0]  xe;
    logic [W-1:0]  x3e;
    logic [W-1:0]  m;
    logic          s;
    pp_d  = '0;
    neg_d = '0;
    c     = '0;
    m     = '0;
    s     = 1'b0;
    xe    = W'($signed(a_x));
    x3e   = W'($signed(a_x3));
    for (int i = 0; i < int'(NPP); i++) begin
      c = a_code[CW*i +: CW];
      if (c[0])      m = xe;
      else if (c[1]) m = xe << 1;
      else if (c[2]) m = x3e;
      else if (c[3]) m = xe << 2;
      else           m = '0;
      s = c[4] & (|c[3:0]);
      pp_d[W*i +: W] = s ? ~m : m;
      neg_d[i] = s;
    end
  end

  // Stage A: operand capture and Booth encoding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_x     <= '0;
      a_x3    <= '0;
      a_code  <= '0;
    end else begin
      if (in_fire) begin
        a_valid <= 1'b1;
        a_x     <= x_in;
        a_x3    <= x3_d;
        a_code  <= code_d;
      end else if (a_adv) begin
        a_valid <= 1'b0;
      end
    end
  end

  // Stage B: partial-product rows, held while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_valid <= 1'b0;
      pp_out  <= '0;
      neg_out <= '0;
    end else if (b_adv) begin
      b_valid <= a_valid;
      if (a_valid) begin
        pp_out  <= pp_d;
        neg_out <= neg_d;
      end
    end
  end

`ifdef R8_PPGEN_OPCOUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (b_valid && out_ready && (op_count != 16'hFFFF)) begin
      op_count <= op_count + 16'd1;
    end
  end
`else
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_r8_pp_generator.sv
// Scoreboard bench for r8_pp_generator: directed vectors, backpressure, reset and random X*Y checks.
module tb_r8_pp_generator;

  localparam int unsigned N   = 16;
  localparam int unsigned NPP = (N + 2) / 3;
  localparam int unsigned W   = N + 3;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     x_in;
  logic [N-1:0]     y_in;
  logic             out_valid;
  logic             out_ready;
  logic [NPP*W-1:0] pp_out;
  logic [NPP-1:0]   neg_out;
  logic [15:0]      op_count;

  r8_pp_generator #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
    .pp_out(pp_out), .neg_out(neg_out), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2*N-1:0] prod;
    bit             directed;
    logic [W-1:0]   row0;
    logic [NPP-1:0] neg;
    bit             upper_zero;
  } exp_t;

  exp_t sb[$];
  exp_t next_exp;
  int   tests = 0;
  int   fails = 0;
  int   out_cnt = 0;
  bit   have_prev = 0;
  logic [NPP*W-1:0] prev_pp;
  logic [NPP-1:0]   prev_neg;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input bit d, input logic [W-1:0] r0, input logic [NPP-1:0] ng,
                              input bit uz);
    exp_t e;
    e.prod = '0;
    e.directed = d;
    e.row0 = r0;
    e.neg = ng;
    e.upper_zero = uz;
    return e;
  endfunction

  function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] x, input logic [N-1:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return (2*N)'(p);
  endfunction

  // Weighted sum of rows as the downstream tree would accumulate them
  function automatic logic [2*N-1:0] wsum(input logic [NPP*W-1:0] pp, input logic [NPP-1:0] ng);
    longint s;
    logic [W-1:0] r;
    s = 0;
    for (int i = 0; i < int'(NPP); i++) begin
      r = pp[i*W +: W];
      s += (longint'($signed(r)) + longint'(ng[i])) <<< (3 * i);
    end
    return (2*N)'(s);
  endfunction

  // Input side: record the expected result of every accepted pair
  always @(negedge clk) begin
    exp_t e;
    if (!rst && in_valid && in_ready) begin
      e = next_exp;
      e.prod = ref_prod(x_in, y_in);
      sb.push_back(e);
    end
  end

  // Output side: check ordering, invariant, directed rows and stall stability
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      have_prev = 0;
    end else begin
      if (have_prev) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_pp", 64'(pp_out ^ prev_pp), 64'd0);
        chk("hold_neg", 64'(neg_out), 64'(prev_neg));
      end
      have_prev = out_valid && !out_ready;
      prev_pp = pp_out;
      prev_neg = neg_out;
      if (out_valid && out_ready) begin
        out_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_set", 64'(out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("weighted_sum", 64'(wsum(pp_out, neg_out)), 64'(e.prod));
          if (e.directed) begin
            chk("row0", 64'(pp_out[W-1:0]), 64'(e.row0));
            chk("neg", 64'(neg_out), 64'(e.neg));
            if (e.upper_zero) chk("upper_rows", 64'(pp_out[NPP*W-1:W] != '0), 64'd0);
          end
        end
      end
    end
  end

  // Present a pair (from posedge+1) and hold it until accepted; returns at posedge+1
  task automatic offer(input logic [N-1:0] x, input logic [N-1:0] y, input exp_t info);
    int t;
    t = 0;
    next_exp = info;
    x_in = x;
    y_in = y;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int iter;
    logic [15:0] exp_cnt;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x_in = '0;
    y_in = '0;
    next_exp = mk(0, '0, '0, 0);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_pp", 64'(pp_out != '0), 64'd0);
    chk("reset_op_count", 64'(op_count), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Latency and the three directed vectors
    out_ready = 1'b1;
    offer(16'h0003, 16'h0001, mk(1, 19'h00003, 6'b000000, 1));
    @(negedge clk);
    chk("latency_cycle1", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("latency_cycle2", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    offer(16'h0005, 16'hFFFF, mk(1, 19'h7FFFA, 6'b000001, 1));
    offer(16'h8000, 16'h0004, mk(1, 19'h1FFFF, 6'b000001, 0));
    drain();

    // Backpressure: two accepted, third stalls, then three consecutive outputs
    out_ready = 1'b0;
    next_exp = mk(0, '0, '0, 0);
    x_in = 16'd3; y_in = 16'd5; in_valid = 1'b1;
    @(negedge clk);
    chk("bp_accept1", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    x_in = 16'd7; y_in = 16'd11;
    @(negedge clk);
    chk("bp_accept2", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    x_in = 16'hFFFE; y_in = 16'd9;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_stalled", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_out0", 64'(out_valid), 64'd1);
    chk("bp_accept3", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_out1", 64'(out_valid), 64'd1);
    @(negedge clk);
    chk("bp_out2", 64'(out_valid), 64'd1);
    drain();

    // Reset with a set presented and another in flight
    out_ready = 1'b0;
    offer(16'd123, 16'd77, mk(0, '0, '0, 0));
    offer(16'd999, 16'hFF00, mk(0, '0, '0, 0));
    @(negedge clk);
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_pp", 64'(pp_out != '0), 64'd0);
    chk("rst_neg", 64'(neg_out), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    sb.delete();
    out_cnt = 0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Random pairs with random backpressure
    acc = 0;
    iter = 0;
    next_exp = mk(0, '0, '0, 0);
    while (acc < 10000 && iter < 80000) begin
      in_valid = ($urandom_range(3) != 0);
      x_in = N'($urandom);
      y_in = N'($urandom);
      out_ready = $urandom_range(1);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk);
      #1;
      iter++;
    end
    in_valid = 1'b0;
    chk("random_accepted", 64'(acc), 64'd10000);
    drain();

`ifdef R8_PPGEN_OPCOUNT_EN
    exp_cnt = (out_cnt > 65535) ? 16'hFFFF : 16'(out_cnt);
`else
    exp_cnt = 16'd0;
`endif
    chk("op_count", 64'(op_count), 64'(exp_cnt));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
